// File: rtl/sass_r_pkg.sv
`default_nettype none
// ============================================================================
// Module : sass_r_pkg
// Brief  : Shared state encoding and timing helpers for the sass serial link.
// Rev    : 1.0  initial release
// ============================================================================
package sass_r_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } state_t;

    localparam int SYNC_STAGES = 2;

    // Clock cycles per bit; 64-bit math because clk_f*t overflows 32 bits.
    function automatic int calc_td(input longint clk_f, input longint t_us, input longint rng);
        return int'((clk_f * t_us) / rng);
    endfunction

    function automatic int calc_cw(input int td);
        return (td < 2) ? 1 : $clog2(td);
    endfunction

endpackage : sass_r_pkg
`default_nettype wire

// File: rtl/sass_sync.sv
`default_nettype none
// ============================================================================
// Module : sass_sync
// Brief  : Multi-stage flop synchronizer with configurable reset value.
// Rev    : 1.0  initial release
// ============================================================================
module sass_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    generate
        if (STAGES == 1) begin : g_single
            assign sync_d = d;
        end else begin : g_chain
            assign sync_d = {sync_q[STAGES-2:0], d};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sass_sync
`default_nettype wire

// File: rtl/sass_r.sv
`default_nettype none
// ============================================================================
// Module : sass_r
// Brief  : Serial frame receiver (start, data_l LSB-first bits, stop).
// Rev    : 1.0  initial release
// ============================================================================
module sass_r
    import sass_r_pkg::*;
#(
    parameter int data_l = 8,
    parameter int t      = 100,
    parameter int clk_f  = 50_000_000,
    parameter int range  = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s,
    output logic [data_l-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              err
);

    localparam int T_D = calc_td(longint'(clk_f), longint'(t), longint'(range));
    localparam int CW  = calc_cw(T_D);
    localparam int BW  = (data_l < 2) ? 1 : $clog2(data_l);
    localparam int FW  = $clog2(SYNC_STAGES + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(T_D / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(T_D - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(data_l - 1);
    localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES);

    logic s_q;

    state_t            state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [BW-1:0]     bit_q,    bit_d;
    logic [data_l-1:0] shift_q,  shift_d;
    logic [data_l-1:0] data_q,   data_d;
    logic              valid_q,  valid_d;
    logic              busy_q,   busy_d;
    logic              err_q,    err_d;
    logic              s_prev_q, s_prev_d;
    logic              armed_q,  armed_d;
    logic [FW-1:0]     fill_q,   fill_d;
    logic              w_fall;

    sass_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (s),
        .q   (s_q)
    );

    // The synchronizer resets to 1, so a line held low through reset would
    // look like a falling edge; only arm once a real high has propagated.
    assign w_fall = armed_q & s_prev_q & ~s_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        s_prev_d = s_q;
        fill_d   = (fill_q == FILL_DONE) ? fill_q : fill_q + 1'b1;
        armed_d  = armed_q | ((fill_q == FILL_DONE) & s_q);

        case (state_q)
            ST_IDLE: begin
                if (w_fall) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!s_q) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d           = '0;
                    shift_d         = shift_q >> 1;
                    shift_d[data_l-1] = s_q;
                    bit_d           = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (s_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            s_prev_q <= 1'b1;
            armed_q  <= 1'b0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            s_prev_q <= s_prev_d;
            armed_q  <= armed_d;
            fill_q   <= fill_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule : sass_r
`default_nettype wire

// File: tb/tb_sass_r.sv
`default_nettype none
// ============================================================================
// Module : tb_sass_r
// Brief  : Self-checking bench for sass_r driving serial frames on s.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sass_r;

    localparam int DL  = 8;
    localparam int TUS = 16;
    localparam int CF  = 1_000_000;
    localparam int RG  = 1_000_000;
    localparam int TD  = CF / RG * TUS;
    localparam int LAT = (DL + 1) * TD + TD / 2 + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s   = 1'b1;
    logic [DL-1:0] data;
    logic          valid;
    logic          busy;
    logic          err;

    sass_r #(
        .data_l (DL),
        .t      (TUS),
        .clk_f  (CF),
        .range  (RG)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s     (s),
        .data  (data),
        .valid (valid),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output observer: collects received payloads and protocol anomalies.
    logic [DL-1:0] got_q[$];
    int            valid_rise_cyc = -1;
    int            err_cnt        = 0;
    int            both_cnt       = 0;
    int            dbl_cnt        = 0;
    int            unstable_cnt   = 0;
    logic          prev_valid     = 1'b0;
    logic [DL-1:0] prev_data      = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_data  <= data;
        end else begin
            if (valid) begin
                got_q.push_back(data);
                if (!prev_valid) valid_rise_cyc <= cyc;
                else             dbl_cnt        <= dbl_cnt + 1;
            end
            if (err)           err_cnt      <= err_cnt + 1;
            if (valid && err)  both_cnt     <= both_cnt + 1;
            if (data !== prev_data && !valid) unstable_cnt <= unstable_cnt + 1;
            prev_valid <= valid;
            prev_data  <= data;
        end
    end

    // Reference model: what a correct receiver must report for what was sent.
    logic [DL-1:0] exp_q[$];
    logic [DL-1:0] last_good = '0;
    int            start_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic drive(input logic v, input int n);
        s = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DL-1:0] v, input logic stop_lvl);
        logic [DL-1:0] b;
        b         = v;
        start_cyc = cyc;
        drive(1'b0, TD);
        for (int i = 0; i < DL; i++) drive(b[i], TD);
        drive(stop_lvl, TD);
        if (stop_lvl) begin
            exp_q.push_back(v);
            last_good = v;
        end
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DL-1:0] fixed [5];
        logic [DL-1:0] b;
        int            e0;

        fixed = '{8'd135, 8'd95, 8'd5, 8'd200, 8'd69};

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  64'(data),  64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_busy",  64'(busy),  64'(0));
        check("rst_err",   64'(err),   64'(0));
        rst = 1'b0;
        drive(1'b1, 3 * TD);

        // Back-to-back fixed payloads
        for (int i = 0; i < 5; i++) send_frame(fixed[i], 1'b1);
        drive(1'b1, TD);
        check_frames("b2b");
        check("b2b_err", 64'(err_cnt), 64'(0));

        // Random payloads with random idle gaps (including none)
        for (int i = 0; i < 6; i++) begin
            send_frame(DL'($urandom_range(0, 255)), 1'b1);
            drive(1'b1, $urandom_range(0, TD));
        end
        drive(1'b1, TD);
        check_frames("rand");

        // Short glitch on an idle line
        e0 = err_cnt;
        drive(1'b0, TD / 4);
        drive(1'b1, TD - TD / 4);
        check("glitch_busy", 64'(busy), 64'(0));
        drive(1'b1, 2 * TD);
        check("glitch_valid", 64'(got_q.size()), 64'(0));
        check("glitch_err", 64'(err_cnt), 64'(e0));

        // Framing error: stop bit low, line stays low for 3 bit times
        send_frame(8'hA5, 1'b0);
        check("ferr_err", 64'(err_cnt), 64'(e0 + 1));
        check("ferr_data", 64'(data), 64'(last_good));
        drive(1'b0, 2 * TD);
        check("ferr_busy_low", 64'(busy), 64'(1));
        check("ferr_valid", 64'(got_q.size()), 64'(0));
        drive(1'b1, 5);
        check("ferr_busy_high", 64'(busy), 64'(0));
        drive(1'b1, TD);
        send_frame(8'h3C, 1'b1);
        drive(1'b1, TD);
        check_frames("after_ferr");
        check("after_ferr_err", 64'(err_cnt), 64'(e0 + 1));

        // Reset in the middle of data bit 4 (a low bit) of 0xEF
        e0 = err_cnt;
        b  = 8'hEF;
        drive(1'b0, TD);
        for (int i = 0; i < 4; i++) drive(b[i], TD);
        drive(b[4], TD / 2);
        rst = 1'b1;
        #1;
        check("mrst_data",  64'(data),  64'(0));
        check("mrst_valid", 64'(valid), 64'(0));
        check("mrst_busy",  64'(busy),  64'(0));
        check("mrst_err",   64'(err),   64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        last_good = '0;
        drive(1'b0, 2 * TD);
        check("mrst_low_busy", 64'(busy), 64'(0));
        drive(1'b1, 2 * TD);
        check("mrst_nopulse", 64'(got_q.size()), 64'(0));
        send_frame(8'hFF, 1'b1);
        drive(1'b1, TD);
        check_frames("after_rst");
        check("after_rst_err", 64'(err_cnt), 64'(e0));

        // Single-frame latency from the start-bit falling edge
        send_frame(8'h00, 1'b1);
        drive(1'b1, TD);
        check_range("latency", valid_rise_cyc - start_cyc, LAT - 1, LAT + 1);
        check_frames("lat");

        check("valid_err_overlap", 64'(both_cnt),     64'(0));
        check("valid_width",       64'(dbl_cnt),      64'(0));
        check("data_stable",       64'(unstable_cnt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sass_r
`default_nettype wire
